// File: rtl/fifo_ctrl_param.sv
// Pointer/occupancy controller for a FIFO whose storage is an external dual-port RAM.
// Any depth >= 2 is supported, including non-power-of-two; pointers wrap explicitly at DEPTH-1.
module fifo_ctrl_param #(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = $clog2(DEPTH),
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic              flush,
   input  logic              clr_err,
   output logic              wr_en,
   output logic              rd_en,
   output logic [ADDR_W-1:0] writeAddr,
   output logic [ADDR_W-1:0] readAddr,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_C    = (ADDR_W + 1)'(1);

   // Thresholds are clamped into the range count can hold, so odd parameter
   // choices give "never" or "always" instead of a truncated compare value.
   localparam int  AF_CLAMP = (AF_THRESH < 0) ? 0 : ((AF_THRESH > DEPTH) ? DEPTH + 1 : AF_THRESH);
   localparam int  AE_CLAMP = (AE_THRESH > DEPTH) ? DEPTH : AE_THRESH;
   localparam bit  AE_NEVER = (AE_THRESH < 0);
   localparam logic [ADDR_W:0] AF_T = (ADDR_W + 1)'(AF_CLAMP);
   localparam logic [ADDR_W:0] AE_T = (ADDR_W + 1)'(AE_NEVER ? 0 : AE_CLAMP);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   occ;
   logic              ovf_q;
   logic              udf_q;

   logic set_ovf;
   logic set_udf;

   function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
   endfunction

   // Status decode is purely from registered occupancy.
   assign empty        = (occ == '0);
   assign full         = (occ == DEPTH_C);
   assign almost_full  = (occ >= AF_T);
   assign almost_empty = !AE_NEVER && (occ <= AE_T);

   // Strobes are gated by reset so the RAM sees no activity while reset is held.
   assign wr_en = reset & write & ~full  & ~flush;
   assign rd_en = reset & read  & ~empty & ~flush;

   assign set_ovf = write & full  & ~flush;
   assign set_udf = read  & empty & ~flush;

   assign writeAddr = wr_ptr;
   assign readAddr  = rd_ptr;
   assign count     = occ;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

   // NOTE: sequential state is updated only with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_en) wr_ptr <= next_ptr(wr_ptr);
         if (rd_en) rd_ptr <= next_ptr(rd_ptr);
         // Simultaneous accept leaves occupancy unchanged.
         unique case ({wr_en, rd_en})
            2'b10:   occ <= occ + ONE_C;
            2'b01:   occ <= occ - ONE_C;
            default: occ <= occ;
         endcase
      end
   end

   // Error flags survive flush; a new error in the clearing cycle wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (set_ovf)      ovf_q <= 1'b1;
         else if (clr_err) ovf_q <= 1'b0;
         if (set_udf)      udf_q <= 1'b1;
         else if (clr_err) udf_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Scoreboard bench for fifo_ctrl_param: a 16-deep and a 6-deep instance share stimulus;
// a behavioural model pushes expectations that are popped against sampled outputs.
module tb_fifo_ctrl_param;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic read = 1'b0, write = 1'b0, flush = 1'b0, clr_err = 1'b0;

   logic       wr_en_a, rd_en_a, empty_a, full_a, ae_a, af_a, ovf_a, udf_a;
   logic [3:0] waddr_a, raddr_a;
   logic [4:0] count_a;

   logic       wr_en_b, rd_en_b, empty_b, full_b, ae_b, af_b, ovf_b, udf_b;
   logic [2:0] waddr_b, raddr_b;
   logic [3:0] count_b;

   always #5 clk = ~clk;

   fifo_ctrl_param #(.DEPTH(16)) dut_a (
      .clk(clk), .reset(reset), .read(read), .write(write), .flush(flush), .clr_err(clr_err),
      .wr_en(wr_en_a), .rd_en(rd_en_a), .writeAddr(waddr_a), .readAddr(raddr_a), .count(count_a),
      .empty(empty_a), .full(full_a), .almost_empty(ae_a), .almost_full(af_a),
      .overflow(ovf_a), .underflow(udf_a));

   fifo_ctrl_param #(.DEPTH(6)) dut_b (
      .clk(clk), .reset(reset), .read(read), .write(write), .flush(flush), .clr_err(clr_err),
      .wr_en(wr_en_b), .rd_en(rd_en_b), .writeAddr(waddr_b), .readAddr(raddr_b), .count(count_b),
      .empty(empty_b), .full(full_b), .almost_empty(ae_b), .almost_full(af_b),
      .overflow(ovf_b), .underflow(udf_b));

   typedef struct {
      int depth; int af; int ae;
      int cnt; int wp; int rp; bit ovf; bit udf;
   } model_t;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   model_t m[2];
   exp_t   sb[$];
   int     n_cmp  = 0;
   int     n_fail = 0;

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m[k].cnt = 0; m[k].wp = 0; m[k].rp = 0; m[k].ovf = 0; m[k].udf = 0;
      end
   endtask

   // Expected outputs for the current inputs and pre-edge model state.
   task automatic push_exp(input int k, input bit r, input bit w, input bit f, input bit in_rst);
      bit fl, em;
      string p;
      fl = (m[k].cnt == m[k].depth);
      em = (m[k].cnt == 0);
      p  = (k == 0) ? "d16." : "d6.";
      expect_val({p, "wr_en"},        32'(!in_rst && w && !fl && !f));
      expect_val({p, "rd_en"},        32'(!in_rst && r && !em && !f));
      expect_val({p, "writeAddr"},    32'(m[k].wp));
      expect_val({p, "readAddr"},     32'(m[k].rp));
      expect_val({p, "count"},        32'(m[k].cnt));
      expect_val({p, "empty"},        32'(em));
      expect_val({p, "full"},         32'(fl));
      expect_val({p, "almost_empty"}, 32'(m[k].cnt <= m[k].ae));
      expect_val({p, "almost_full"},  32'(m[k].cnt >= m[k].af));
      expect_val({p, "overflow"},     32'(m[k].ovf));
      expect_val({p, "underflow"},    32'(m[k].udf));
   endtask

   task automatic compare_all();
      check(32'(wr_en_a)); check(32'(rd_en_a)); check(32'(waddr_a)); check(32'(raddr_a));
      check(32'(count_a)); check(32'(empty_a)); check(32'(full_a));  check(32'(ae_a));
      check(32'(af_a));    check(32'(ovf_a));   check(32'(udf_a));
      check(32'(wr_en_b)); check(32'(rd_en_b)); check(32'(waddr_b)); check(32'(raddr_b));
      check(32'(count_b)); check(32'(empty_b)); check(32'(full_b));  check(32'(ae_b));
      check(32'(af_b));    check(32'(ovf_b));   check(32'(udf_b));
   endtask

   task automatic model_step(input bit r, input bit w, input bit f, input bit c);
      for (int k = 0; k < 2; k++) begin
         bit fl, em, we, re;
         fl = (m[k].cnt == m[k].depth);
         em = (m[k].cnt == 0);
         we = w && !fl && !f;
         re = r && !em && !f;
         if (w && fl && !f) m[k].ovf = 1; else if (c) m[k].ovf = 0;
         if (r && em && !f) m[k].udf = 1; else if (c) m[k].udf = 0;
         if (f) begin
            m[k].cnt = 0; m[k].wp = 0; m[k].rp = 0;
         end else begin
            if (we) m[k].wp = (m[k].wp + 1) % m[k].depth;
            if (re) m[k].rp = (m[k].rp + 1) % m[k].depth;
            m[k].cnt = m[k].cnt + int'(we) - int'(re);
         end
      end
   endtask

   // One clock: drive at negedge, check combinational view, advance model at posedge.
   task automatic cycle(input bit r, input bit w, input bit f, input bit c);
      @(negedge clk);
      read = r; write = w; flush = f; clr_err = c;
      push_exp(0, r, w, f, 1'b0);
      push_exp(1, r, w, f, 1'b0);
      #1 compare_all();
      @(posedge clk);
      model_step(r, w, f, c);
   endtask

   // Reset is pulled mid-cycle with a write pending; outputs must clear before any edge.
   task automatic reset_pulse();
      @(negedge clk);
      read = 1'b0; write = 1'b1; flush = 1'b0; clr_err = 1'b0;
      #2 reset = 1'b0;
      model_reset();
      push_exp(0, 1'b0, 1'b1, 1'b0, 1'b1);
      push_exp(1, 1'b0, 1'b1, 1'b0, 1'b1);
      #1 compare_all();
      @(posedge clk);
      @(negedge clk);
      push_exp(0, 1'b0, 1'b1, 1'b0, 1'b1);
      push_exp(1, 1'b0, 1'b1, 1'b0, 1'b1);
      #1 compare_all();
      write = 1'b0;
      reset = 1'b1;
   endtask

   initial begin
      int wseq[9];
      wseq = '{0, 1, 2, 3, 4, 5, 0, 1, 2};
      m[0] = '{depth: 16, af: 12, ae: 4, cnt: 0, wp: 0, rp: 0, ovf: 0, udf: 0};
      m[1] = '{depth: 6,  af: 2,  ae: 4, cnt: 0, wp: 0, rp: 0, ovf: 0, udf: 0};

      // Power-on reset, then a mid-operation reset after five writes.
      reset_pulse();
      repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      reset_pulse();

      // Fill to full, overflow attempt, then clear the error.
      repeat (16) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      #1 expect_val("d16.full_after_16", 32'd16);
      check(32'(count_a));
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      #1 expect_val("d16.overflow_after_17th", 32'd1);
      check(32'(ovf_a));
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // Read+write when full: only the read is taken.
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      #1 expect_val("d16.count_full_rw", 32'd15);
      check(32'(count_a));

      // Drain to 5, then simultaneous read/write holds count.
      repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      #1 expect_val("d16.count_rw_at5", 32'd5);
      check(32'(count_a));

      // Empty, underflow, set-beats-clear, then flush overriding read/write.
      repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (7) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      #1 expect_val("d16.underflow_after_flush", 32'd1);
      check(32'(udf_a));

      // Non-power-of-two wrap on the 6-deep instance.
      reset_pulse();
      for (int i = 0; i < 9; i++) begin
         #1 expect_val($sformatf("d6.wptr_seq[%0d]", i), 32'(wseq[i]));
         check(32'(waddr_b));
         cycle(1'b0, 1'b1, 1'b0, 1'b0);
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
         #1 expect_val($sformatf("d6.rptr_in_range[%0d]", i), 32'd1);
         check(32'(raddr_b < 3'd6));
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      #1 expect_val("d6.empty_end", 32'd1);
      check(32'(empty_b));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
